coin_ejector_seq: RTL and testbench
===================================

// Module: coin_ejector_seq
// PURPOSE
//  Back end of the coin dispenser. Receives per-denomination coin counts from the dispenser FSM
//  (one-cycle load strobe, issued on collect-coins) and ejects coins one at a time.
//  Order is Rs.5, then Rs.2, then Rs.1. Each coin gets a timed solenoid pulse and must be
//  confirmed by the chute sensor. Reports the running rupee total, completion and jam faults.
// PARAMETERS
//  PULSE_CYCLES   4    eject solenoid high time per coin, in clk cycles (>=1)
//  SENSE_TIMEOUT  255  max cycles in WAIT_SENSE without a sensor pulse before timeout (>=1)
//  CNT_W          9    width of each per-denomination count input
// PORTS
//  clk_in            in   1        system clock, rising edge
//  rst_in            in   1        asynchronous active-low reset
//  load_in           in   1        1-cycle strobe: latch counts and start; honoured only when ready_out=1
//  rs5_count_in      in   CNT_W    number of Rs.5 coins to eject
//  rs2_count_in      in   CNT_W    number of Rs.2 coins to eject
//  rs1_count_in      in   CNT_W    number of Rs.1 coins to eject
//  coin_sensed_in    in   1        chute sensor, 1-cycle pulse per coin passing
//  clr_fault_in      in   1        clears JAM, returns to IDLE
//  ready_out         out  1        1 in IDLE only
//  busy_out          out  1        1 in PICK/PULSE/WAIT_SENSE/DONE
//  eject5_out        out  1        Rs.5 solenoid drive (registered)
//  eject2_out        out  1        Rs.2 solenoid drive (registered)
//  eject1_out        out  1        Rs.1 solenoid drive (registered)
//  total_out         out  12       rupees confirmed dispensed since last load
//  done_out          out  1        1-cycle pulse: all latched coins confirmed
//  jam_out           out  1        level: sensor timeout; held until clr_fault_in or reset
// BEHAVIOUR
//  Reset: state=IDLE, ready_out=1, all other outputs 0, latched counts/timers/flags cleared.
//   Reset is effective at any time; a coin in flight is not counted.
//  States: IDLE -> PICK -> PULSE -> WAIT_SENSE -> PICK ... -> DONE -> IDLE; WAIT_SENSE -> JAM -> IDLE.
//  IDLE: on load_in go to PICK; latch the three counts; clear total_out.
//   load_in in any other state is ignored. coin_sensed_in in IDLE/PICK/DONE/JAM is ignored.
//  PICK (1 cycle): select highest denomination with nonzero remaining count, go to PULSE.
//   If all remaining counts are 0, go to DONE.
//  PULSE: exactly one selected eject*_out high for PULSE_CYCLES consecutive cycles.
//   First high cycle is the cycle after PICK. The eject lines are never high simultaneously.
//   A sensor pulse during PULSE sets sensed_flag. At pulse end: if sensed_flag, confirm coin;
//   otherwise go to WAIT_SENSE with timer=0.
//  WAIT_SENSE: timer increments each cycle. coin_sensed_in=1 -> confirm coin.
//   timer reaching SENSE_TIMEOUT with no sensor pulse -> timeout.
//  Confirm coin: decrement selected count, add 5/2/1 to total_out (registered, visible next cycle),
//   clear sensed_flag, go to PICK. Extra sensor pulses beyond one per coin are ignored.
//  Timeout: go to JAM. In JAM: jam_out=1, eject lines 0, busy_out=0, ready_out=0.
//   total_out holds confirmed value. clr_fault_in -> IDLE next cycle, remaining counts discarded.
//   clr_fault_in outside JAM is ignored.
//  DONE (1 cycle): done_out=1, then IDLE. total_out holds until next accepted load.
//  Latency, all-zero load: load at cycle t -> PICK t+1 -> DONE t+2 (done_out=1 at t+2) -> ready at t+3.
//  Width: total_out max 5*511+2*511+511=4088, fits 12 bits, no wrap. Counts never underflow.
// CONFIGURATION
//  COIN_EJECT_RETRY_EN defined: on first timeout for a coin, return to PULSE once
//   (same denomination, retry flag set). A second timeout for that coin -> JAM.
//   The retry flag clears on confirm.
//  COIN_EJECT_RETRY_EN undefined: first timeout -> JAM.
// TESTING
//  1. PULSE_CYCLES=4; load 5/2/1 counts = 2/1/1; sensor 3 cycles after each pulse end
//     -> eject5 two 4-cycle pulses, then eject2 one, then eject1 one; total_out=13;
//     one done_out pulse; ready_out=1.
//  2. load counts 0/0/0 -> no eject activity; done_out at load+2; total_out=0.
//  3. load 1/1/0; sensor only for the Rs.5 coin -> jam_out=1 SENSE_TIMEOUT cycles after
//     eject2 falls; total_out=5; clr_fault_in -> ready_out=1 next cycle.
//  4. load_in pulsed while busy with counts 9/9/9 -> ignored, original job completes unchanged;
//     coin_sensed_in pulses in IDLE -> total_out unchanged.
//  5. Sensor pulse during the PULSE window -> coin confirmed at pulse end, no WAIT_SENSE;
//     rst_in low mid-PULSE -> eject low immediately, all outputs at reset values.
//  6. With COIN_EJECT_RETRY_EN: load 0/1/0, no sensor on first pulse, sensor on retry pulse
//     -> two eject2 pulses, total_out=2, done_out, jam_out stays 0.

Source files
------------

// File: rtl/coin_ejector_seq.sv
// Coin ejector back end: ejects latched Rs.5/Rs.2/Rs.1 coins one at a time with sensor confirmation.
// Optional feature: define COIN_EJECT_RETRY_EN to re-pulse a coin once after its first sensor timeout.
module coin_ejector_seq #(
    parameter int PULSE_CYCLES  = 4,
    parameter int SENSE_TIMEOUT = 255,
    parameter int CNT_W         = 9
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [CNT_W-1:0] rs5_count_in,
    input  logic [CNT_W-1:0] rs2_count_in,
    input  logic [CNT_W-1:0] rs1_count_in,
    input  logic             coin_sensed_in,
    input  logic             clr_fault_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             eject5_out,
    output logic             eject2_out,
    output logic             eject1_out,
    output logic [11:0]      total_out,
    output logic             done_out,
    output logic             jam_out
);

    localparam int TMR_MAX = (PULSE_CYCLES > SENSE_TIMEOUT) ? PULSE_CYCLES : SENSE_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SENSE_LAST = TMR_W'(SENSE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PICK, S_PULSE, S_WAIT_SENSE, S_DONE, S_JAM
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE, SEL_5, SEL_2, SEL_1
    } sel_t;

    state_t           state_q, state_d;
    sel_t             sel_q, sel_d;
    logic [CNT_W-1:0] cnt5_q, cnt5_d;
    logic [CNT_W-1:0] cnt2_q, cnt2_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             sensed_q, sensed_d;
    logic             retry_q, retry_d;
    logic [11:0]      total_q, total_d;
    logic [2:0]       eject_q, eject_d;
    logic             confirm;
    logic             timeout;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= S_IDLE;
            sel_q    <= SEL_NONE;
            cnt5_q   <= '0;
            cnt2_q   <= '0;
            cnt1_q   <= '0;
            timer_q  <= '0;
            sensed_q <= 1'b0;
            retry_q  <= 1'b0;
            total_q  <= '0;
            eject_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt5_q   <= cnt5_d;
            cnt2_q   <= cnt2_d;
            cnt1_q   <= cnt1_d;
            timer_q  <= timer_d;
            sensed_q <= sensed_d;
            retry_q  <= retry_d;
            total_q  <= total_d;
            eject_q  <= eject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt5_d   = cnt5_q;
        cnt2_d   = cnt2_q;
        cnt1_d   = cnt1_q;
        timer_d  = timer_q;
        sensed_d = sensed_q;
        retry_d  = retry_q;
        total_d  = total_q;
        confirm  = 1'b0;
        timeout  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_in) begin
                    state_d  = S_PICK;
                    cnt5_d   = rs5_count_in;
                    cnt2_d   = rs2_count_in;
                    cnt1_d   = rs1_count_in;
                    total_d  = '0;
                    sensed_d = 1'b0;
                    retry_d  = 1'b0;
                end
            end
            S_PICK: begin
                timer_d  = '0;
                sensed_d = 1'b0;
                if (cnt5_q != '0) begin
                    sel_d   = SEL_5;
                    state_d = S_PULSE;
                end else if (cnt2_q != '0) begin
                    sel_d   = SEL_2;
                    state_d = S_PULSE;
                end else if (cnt1_q != '0) begin
                    sel_d   = SEL_1;
                    state_d = S_PULSE;
                end else begin
                    sel_d   = SEL_NONE;
                    state_d = S_DONE;
                end
            end
            S_PULSE: begin
                timer_d = timer_q + 1'b1;
                if (coin_sensed_in) sensed_d = 1'b1;
                // A sensor hit on the final pulse cycle still counts for this pulse.
                if (timer_q == PULSE_LAST) begin
                    timer_d = '0;
                    if (sensed_q || coin_sensed_in) confirm = 1'b1;
                    else state_d = S_WAIT_SENSE;
                end
            end
            S_WAIT_SENSE: begin
                timer_d = timer_q + 1'b1;
                if (coin_sensed_in) confirm = 1'b1;
                else if (timer_q == SENSE_LAST) timeout = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_JAM: begin
                if (clr_fault_in) begin
                    state_d  = S_IDLE;
                    sel_d    = SEL_NONE;
                    cnt5_d   = '0;
                    cnt2_d   = '0;
                    cnt1_d   = '0;
                    timer_d  = '0;
                    sensed_d = 1'b0;
                    retry_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Confirmation only happens for a denomination PICK found nonzero, so no underflow.
        if (confirm) begin
            state_d  = S_PICK;
            sensed_d = 1'b0;
            retry_d  = 1'b0;
            case (sel_q)
                SEL_5: begin
                    cnt5_d  = cnt5_q - 1'b1;
                    total_d = total_q + 12'd5;
                end
                SEL_2: begin
                    cnt2_d  = cnt2_q - 1'b1;
                    total_d = total_q + 12'd2;
                end
                SEL_1: begin
                    cnt1_d  = cnt1_q - 1'b1;
                    total_d = total_q + 12'd1;
                end
                default: ;
            endcase
        end

        if (timeout) begin
`ifdef COIN_EJECT_RETRY_EN
            if (!retry_q) begin
                state_d  = S_PULSE;
                retry_d  = 1'b1;
                timer_d  = '0;
                sensed_d = 1'b0;
            end else begin
                state_d = S_JAM;
            end
`else
            state_d = S_JAM;
`endif
        end

        // Solenoid drive is registered from the next state so it aligns exactly with PULSE.
        eject_d = '0;
        if (state_d == S_PULSE) begin
            case (sel_d)
                SEL_5:   eject_d = 3'b100;
                SEL_2:   eject_d = 3'b010;
                SEL_1:   eject_d = 3'b001;
                default: eject_d = 3'b000;
            endcase
        end
    end

    assign ready_out  = (state_q == S_IDLE);
    assign busy_out   = (state_q == S_PICK) || (state_q == S_PULSE) ||
                        (state_q == S_WAIT_SENSE) || (state_q == S_DONE);
    assign done_out   = (state_q == S_DONE);
    assign jam_out    = (state_q == S_JAM);
    assign eject5_out = eject_q[2];
    assign eject2_out = eject_q[1];
    assign eject1_out = eject_q[0];
    assign total_out  = total_q;

endmodule

// File: tb/tb_coin_ejector_seq.sv
// Randomized bench for coin_ejector_seq: a per-job timeline model predicts every output each cycle.
module tb_coin_ejector_seq;

    localparam int P    = 4;
    localparam int ST   = 12;
    localparam int CW   = 9;
    localparam int MAXC = 1024;
`ifdef COIN_EJECT_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          load_in = 1'b0;
    logic [CW-1:0] rs5_count_in = '0;
    logic [CW-1:0] rs2_count_in = '0;
    logic [CW-1:0] rs1_count_in = '0;
    logic          coin_sensed_in = 1'b0;
    logic          clr_fault_in = 1'b0;
    logic          ready_out, busy_out, eject5_out, eject2_out, eject1_out;
    logic [11:0]   total_out;
    logic          done_out, jam_out;

    coin_ejector_seq #(
        .PULSE_CYCLES (P),
        .SENSE_TIMEOUT(ST),
        .CNT_W        (CW)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .load_in       (load_in),
        .rs5_count_in  (rs5_count_in),
        .rs2_count_in  (rs2_count_in),
        .rs1_count_in  (rs1_count_in),
        .coin_sensed_in(coin_sensed_in),
        .clr_fault_in  (clr_fault_in),
        .ready_out     (ready_out),
        .busy_out      (busy_out),
        .eject5_out    (eject5_out),
        .eject2_out    (eject2_out),
        .eject1_out    (eject1_out),
        .total_out     (total_out),
        .done_out      (done_out),
        .jam_out       (jam_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    int prev_total = 0;

    // Expected timeline for one job, indexed by cycle relative to the load cycle.
    bit       e_ready [MAXC];
    bit       e_busy  [MAXC];
    bit       e_done  [MAXC];
    bit       e_jam   [MAXC];
    bit [2:0] e_ej    [MAXC];
    int       e_tot   [MAXC];
    bit       sens    [MAXC];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] obs_vec();
        return {13'd0, ready_out, busy_out, done_out, jam_out,
                eject5_out, eject2_out, eject1_out, total_out};
    endfunction

    // Sensor delay in cycles after pulse start for one attempt; -1 means the sensor never fires.
    function automatic int pick_delay(input int mode, input int coin, input int attempt);
        case (mode)
            1:       return P + 2;
            2:       return (coin == 2) ? -1 : 1;
            3:       return 1;
            4:       return (attempt == 0) ? -1 : 1;
            default: return ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, P + ST - 1));
        endcase
    endfunction

    task automatic run_job(input int c5, input int c2, input int c1, input int mode, input string name);
        int       coins[$];
        int       x, s, d, tries, tot, jam_at, clr_at, done_at, last;
        bit       jammed, pending;
        bit [2:0] ejb;
        logic [31:0] exp_v;

        for (int n = 0; n < MAXC; n++) begin
            e_ready[n] = 0; e_busy[n] = 0; e_done[n] = 0; e_jam[n] = 0;
            e_ej[n] = 3'b000; e_tot[n] = 0; sens[n] = 0;
        end
        repeat (c5) coins.push_back(5);
        repeat (c2) coins.push_back(2);
        repeat (c1) coins.push_back(1);

        x = 1; tot = 0; jammed = 0; jam_at = 0; clr_at = -1;
        e_tot[0] = prev_total;
        e_ready[0] = 1;
        for (int i = 0; i < coins.size() && !jammed; i++) begin
            s = x + 1;
            tries = 0;
            ejb = (coins[i] == 5) ? 3'b100 : (coins[i] == 2) ? 3'b010 : 3'b001;
            d = pick_delay(mode, coins[i], 0);
            pending = 1;
            while (pending) begin
                for (int m = 0; m < P; m++) e_ej[s + m] = ejb;
                if (d >= 0) begin
                    sens[s + d] = 1;
                    x = (d < P) ? s + P : s + d + 1;
                    tot += coins[i];
                    for (int m = x; m < MAXC; m++) e_tot[m] = tot;
                    sens[x] = 1'($urandom_range(0, 1));
                    pending = 0;
                end else if (RETRY && tries == 0) begin
                    tries = 1;
                    s = s + P + ST;
                    d = pick_delay(mode, coins[i], 1);
                end else begin
                    jammed = 1;
                    jam_at = s + P + ST;
                    pending = 0;
                end
            end
        end

        if (jammed) begin
            clr_at = jam_at + int'($urandom_range(1, 4));
            for (int n = 1; n < jam_at; n++) e_busy[n] = 1;
            for (int n = jam_at; n <= clr_at; n++) begin
                e_jam[n] = 1;
                sens[n] = 1'($urandom_range(0, 1));
            end
            last = clr_at + 3;
            for (int n = clr_at + 1; n <= last; n++) begin
                e_ready[n] = 1;
                sens[n] = 1'($urandom_range(0, 1));
            end
        end else begin
            done_at = x + 1;
            for (int n = 1; n <= done_at; n++) e_busy[n] = 1;
            e_done[done_at] = 1;
            sens[done_at] = 1'($urandom_range(0, 1));
            last = done_at + 3;
            for (int n = done_at + 1; n <= last; n++) begin
                e_ready[n] = 1;
                sens[n] = 1'($urandom_range(0, 1));
            end
        end

        for (int n = 0; n <= last; n++) begin
            load_in      = (n == 0) || (!e_ready[n] && $urandom_range(0, 7) == 0);
            rs5_count_in = (n == 0) ? CW'(c5) : CW'(9);
            rs2_count_in = (n == 0) ? CW'(c2) : CW'(9);
            rs1_count_in = (n == 0) ? CW'(c1) : CW'(9);
            coin_sensed_in = sens[n];
            clr_fault_in = (n == clr_at) || (!e_jam[n] && $urandom_range(0, 7) == 0);
            exp_v = {13'd0, e_ready[n], e_busy[n], e_done[n], e_jam[n], e_ej[n], 12'(e_tot[n])};
            check_eq($sformatf("%s c%0d", name, n), obs_vec(), exp_v);
            @(posedge clk_in);
            #1;
        end
        load_in = 0; coin_sensed_in = 0; clr_fault_in = 0;
        prev_total = tot;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_eq("reset_hold", obs_vec(), 32'h0004_0000);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        check_eq("reset_idle", obs_vec(), 32'h0004_0000);

        run_job(2, 1, 1, 1, "t1_mix");
        run_job(0, 0, 0, 0, "t2_zero");
        run_job(1, 1, 0, 2, "t3_jam");
        run_job(9, 0, 0, 1, "t4_busy_load");
        run_job(1, 2, 1, 3, "t5_early_sense");
        for (int j = 0; j < 14; j++)
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 0, $sformatf("rnd%0d", j));
`ifdef COIN_EJECT_RETRY_EN
        run_job(0, 1, 0, 4, "t6_retry");
`endif

        // Asynchronous reset in the middle of a Rs.5 pulse, after the sensor already fired.
        run_job(0, 0, 1, 3, "pre_rst");
        load_in = 1; rs5_count_in = CW'(1); rs2_count_in = '0; rs1_count_in = '0;
        @(posedge clk_in); #1;
        load_in = 0;
        @(posedge clk_in); #1;
        coin_sensed_in = 1;
        @(posedge clk_in); #1;
        coin_sensed_in = 0;
        check_eq("mid_pulse", obs_vec(), 32'h0002_4000);
        #2;
        rst_in = 1'b0;
        #1;
        check_eq("async_rst", obs_vec(), 32'h0004_0000);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        check_eq("post_rst", obs_vec(), 32'h0004_0000);
        prev_total = 0;
        run_job(1, 0, 1, 0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
